// File: rtl/dm_cache_pkg.sv
// Constants and state encoding shared by the direct-mapped cache and its
// memory-side line-fill responder.
package dm_cache_pkg;

    localparam int ADDR_W     = 32;
    localparam int LINE_WORDS = 16;
    localparam int OFFSET_W   = 4;
    localparam int INDEX_W    = 8;
    localparam int TAG_W      = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } fill_state_t;

endpackage

// File: rtl/dm_line_fill_responder.sv
// Memory-side line-fill responder: accepts one request, waits LATENCY cycles,
// then streams LINE_WORDS beats (word = line base + beat index) under valid/ready.
module dm_line_fill_responder
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int OFFSET_W   = $clog2(LINE_WORDS),
    parameter int LATENCY    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [ADDR_W-1:0]   resp_data,
    output logic [OFFSET_W-1:0] resp_idx,
    output logic                resp_last,
    output logic                busy,
    output logic [31:0]         fill_count
);

    localparam logic [7:0]          LAT_CNT     = 8'(LATENCY);
    localparam logic [OFFSET_W-1:0] LAST_IDX    = OFFSET_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0]   OFFSET_MASK = ADDR_W'(LINE_WORDS - 1);

    fill_state_t         state;
    fill_state_t         state_next;
    logic [7:0]          cnt;
    logic [7:0]          cnt_next;
    logic [ADDR_W-1:0]   base;
    logic [OFFSET_W-1:0] idx;
    logic                accept;
    logic                beat_fire;
    logic                line_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Handshake-facing outputs depend on state alone; resp_ready/req_valid only steer next state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        beat_fire  = 1'b0;
        line_done  = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = BURST;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_CNT;
                    end
                end
            end
            WAIT: begin
                // Leaving on the count of 1 makes WAIT last exactly LATENCY cycles.
                if (cnt <= 8'd1) begin
                    state_next = BURST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            BURST: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    beat_fire = 1'b1;
                    if (idx == LAST_IDX) begin
                        line_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base       <= '0;
            idx        <= '0;
            fill_count <= '0;
        end else begin
            if (accept) begin
                base <= req_addr & ~OFFSET_MASK;
                idx  <= '0;
            end else if (beat_fire) begin
                idx <= line_done ? '0 : idx + OFFSET_W'(1);
            end
            if (line_done) begin
                fill_count <= fill_count + 32'd1;
            end
        end
    end

    // base is line-aligned, so adding idx never carries past the offset field.
    assign resp_data = base + {{(ADDR_W-OFFSET_W){1'b0}}, idx};
    assign resp_idx  = idx;
    assign resp_last = (idx == LAST_IDX);

endmodule

// File: tb/tb_dm_line_fill_responder.sv
// Bench for dm_line_fill_responder: one instance with LATENCY=4, one with LATENCY=0,
// expected beats queued at request time and popped on each handshake.
module tb_dm_line_fill_responder;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        resp_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int fills_a = 0;
    beat_t exp_q[$];

    logic        rv_in_a, rv_in_z, rr_in_a, rr_in_z;
    logic        rq_a, rq_z, vl_a, vl_z, ls_a, ls_z, bs_a, bs_z;
    logic [31:0] dt_a, dt_z, fc_a, fc_z;
    logic [3:0]  ix_a, ix_z;

    assign rv_in_a = req_valid & ~sel;
    assign rv_in_z = req_valid & sel;
    assign rr_in_a = resp_ready & ~sel;
    assign rr_in_z = resp_ready & sel;

    dm_line_fill_responder #(.ADDR_W(32), .LINE_WORDS(16), .OFFSET_W(4), .LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_in_a), .req_addr(req_addr), .req_ready(rq_a),
        .resp_valid(vl_a), .resp_ready(rr_in_a), .resp_data(dt_a), .resp_idx(ix_a),
        .resp_last(ls_a), .busy(bs_a), .fill_count(fc_a));

    dm_line_fill_responder #(.ADDR_W(32), .LINE_WORDS(16), .OFFSET_W(4), .LATENCY(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .req_valid(rv_in_z), .req_addr(req_addr), .req_ready(rq_z),
        .resp_valid(vl_z), .resp_ready(rr_in_z), .resp_data(dt_z), .resp_idx(ix_z),
        .resp_last(ls_z), .busy(bs_z), .fill_count(fc_z));

    logic        o_ready, o_valid, o_last, o_busy;
    logic [31:0] o_data, o_fill;
    logic [3:0]  o_idx;
    logic [71:0] vec_a, vec_z;
    logic [71:0] rst_vec;

    assign o_ready = sel ? rq_z : rq_a;
    assign o_valid = sel ? vl_z : vl_a;
    assign o_last  = sel ? ls_z : ls_a;
    assign o_busy  = sel ? bs_z : bs_a;
    assign o_data  = sel ? dt_z : dt_a;
    assign o_fill  = sel ? fc_z : fc_a;
    assign o_idx   = sel ? ix_z : ix_a;
    assign vec_a   = {rq_a, vl_a, dt_a, ix_a, ls_a, bs_a, fc_a};
    assign vec_z   = {rq_z, vl_z, dt_z, ix_z, ls_z, bs_z, fc_z};
    assign rst_vec = {1'b1, 71'b0};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        fills_a = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (vec_a !== rst_vec) begin
            failures++;
            $display("FAIL reset_in_a: got %h want %h", vec_a, rst_vec);
        end
        checks++;
        if (vec_z !== rst_vec) begin
            failures++;
            $display("FAIL reset_in_z: got %h want %h", vec_z, rst_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (vec_a !== rst_vec || vec_z !== rst_vec) begin
            failures++;
            $display("FAIL reset_release: got %h / %h want %h", vec_a, vec_z, rst_vec);
        end
    endtask

    // One complete fill; stall=1 drives resp_ready 1,0,0,1,0,0,... on valid cycles.
    task automatic do_fill(input logic [31:0] addr, input bit stall, input string name,
                           input logic [31:0] exp_fill);
        int k, vc, beats, first_k, lat;
        bit held;
        beat_t hold_b, got, e;
        logic [31:0] base;
        lat  = sel ? 0 : 4;
        base = addr & 32'hFFFF_FFF0;
        exp_q.delete();
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addr;
        resp_ready = 1'b0;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_req_ready: got %b want 1", name, o_ready);
        end
        for (int i = 0; i < 16; i++) begin
            e.data = base + 32'(i);
            e.idx  = 4'(i);
            e.last = (i == 15);
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = ~addr;
        k = 1; vc = 0; beats = 0; first_k = -1; held = 1'b0;
        while (beats < 16 && k < 200) begin
            got = {o_data, o_idx, o_last};
            if (held) begin
                checks++;
                if (o_valid !== 1'b1 || got !== hold_b) begin
                    failures++;
                    $display("FAIL %s_stall_hold: got v=%b %h want v=1 %h", name, o_valid, got, hold_b);
                end
            end
            if (o_valid === 1'b1 && first_k < 0) begin
                first_k = k;
                checks++;
                if (k != lat + 1) begin
                    failures++;
                    $display("FAIL %s_first_beat_cycle: got %0d want %0d", name, k, lat + 1);
                end
            end
            if (o_valid === 1'b1) begin
                resp_ready = stall ? (vc % 3 == 0) : 1'b1;
                vc++;
                if (resp_ready) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (got !== e) begin
                        failures++;
                        $display("FAIL %s_beat%0d: got %h want %h", name, beats, got, e);
                    end
                    beats++;
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    hold_b = got;
                end
            end else begin
                resp_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        resp_ready = 1'b0;
        checks++;
        if (beats != 16) begin
            failures++;
            $display("FAIL %s_beat_count: got %0d want 16", name, beats);
        end
        if (!stall) begin
            checks++;
            if (k != lat + 17) begin
                failures++;
                $display("FAIL %s_line_time: got %0d want %0d", name, k, lat + 17);
            end
        end
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_fill !== exp_fill) begin
            failures++;
            $display("FAIL %s_after: got rdy=%b vld=%b busy=%b fill=%0d want 1 0 0 %0d",
                     name, o_ready, o_valid, o_busy, o_fill, exp_fill);
        end
    endtask

    task automatic test_basic();
        sel = 1'b0;
        fills_a++;
        do_fill(32'h0000_1234, 1'b0, "basic", 32'(fills_a));
    endtask

    task automatic test_stall();
        sel = 1'b0;
        fills_a++;
        do_fill(32'h0000_1234, 1'b1, "stall", 32'(fills_a));
    endtask

    task automatic test_zero_latency();
        sel = 1'b1;
        do_fill(32'hFFFF_FFF0, 1'b0, "lat0", 32'd1);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        int k, n_acc, beats, last_acc;
        bit pend;
        beat_t got, e;
        addrs[0] = 32'h0000_2000;
        addrs[1] = 32'h0000_3458;
        addrs[2] = 32'hABCD_EF07;
        sel = 1'b0;
        apply_reset();
        exp_q.delete();
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = addrs[0];
        resp_ready = 1'b1;
        k = 0; n_acc = 0; beats = 0; last_acc = -1; pend = 1'b0;
        while (beats < 48 && k < 400) begin
            if (pend) begin
                pend = 1'b0;
                if (n_acc == 3) req_valid = 1'b0;
                else req_addr = addrs[n_acc];
            end
            if (o_busy === 1'b1) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_ready_while_busy: got %b want 0 at cycle %0d", o_ready, k);
                end
            end
            if (req_valid && o_ready === 1'b1) begin
                for (int i = 0; i < 16; i++) begin
                    e.data = (req_addr & 32'hFFFF_FFF0) + 32'(i);
                    e.idx  = 4'(i);
                    e.last = (i == 15);
                    exp_q.push_back(e);
                end
                if (n_acc > 0) begin
                    checks++;
                    if (k - last_acc != 21) begin
                        failures++;
                        $display("FAIL b2b_spacing%0d: got %0d want 21", n_acc, k - last_acc);
                    end
                end
                last_acc = k;
                n_acc++;
                pend = 1'b1;
            end
            if (o_valid === 1'b1) begin
                got = {o_data, o_idx, o_last};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b2b_unexpected_beat: got %h want none", got);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (got !== e) begin
                        failures++;
                        $display("FAIL b2b_beat%0d: got %h want %h", beats, got, e);
                    end
                end
                beats++;
            end
            @(negedge clk);
            k++;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        checks++;
        if (beats != 48 || n_acc != 3) begin
            failures++;
            $display("FAIL b2b_counts: got beats=%0d acc=%0d want 48 3", beats, n_acc);
        end
        checks++;
        if (o_fill !== 32'd3) begin
            failures++;
            $display("FAIL b2b_fill_count: got %0d want 3", o_fill);
        end
        fills_a = 3;
    endtask

    task automatic test_reset_mid_burst();
        int k;
        bit hit;
        sel = 1'b0;
        apply_reset();
        do_fill(32'h0000_4444, 1'b0, "pre", 32'd1);
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = 32'h0000_7700;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        hit = 1'b0;
        while (!hit && k < 100) begin
            if (o_valid === 1'b1 && o_idx === 4'd7) hit = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midrst_beat7_seen: got none want idx 7 within 100 cycles");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (vec_a !== rst_vec) begin
            failures++;
            $display("FAIL midrst_immediate: got %h want %h", vec_a, rst_vec);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        fills_a    = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_fill !== 32'd0) begin
                failures++;
                $display("FAIL midrst_no_partial%0d: got vld=%b fill=%0d want 0 0", i, o_valid, o_fill);
            end
        end
        resp_ready = 1'b0;
        fills_a++;
        do_fill(32'h0000_5557, 1'b0, "post", 32'(fills_a));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_latency();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_line_fill_responder.md
# dm_line_fill_responder

Memory-side responder for the direct-mapped cache's line-fill path. It accepts one line-fill request at a time, models a fixed main-memory access latency, then returns the line as a burst of `LINE_WORDS` beats under valid/ready flow control. Each returned word equals its own byte-agnostic word address: line base plus beat index. It sits between the cache miss handler (initiator) and the testbench/top level, and counts completed fills for comparison against the cache's miss count.

## Interface
- `ADDR_W`, default 32: address and data width.
- `LINE_WORDS`, default 16: beats per line; must be a power of 2 and at least 2.
- `OFFSET_W`, default log2(`LINE_WORDS`) = 4: number of line-offset bits.
- `LATENCY`, default 4: wait cycles between request acceptance and the first beat; range 0..255.

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: fill request present.
- `req_addr`  in  `ADDR_W`: any address within the missed line; bits [OFFSET_W-1:0] are ignored.
- `req_ready`  out  1: responder can accept a request.
- `resp_valid`  out  1: beat present.
- `resp_ready`  in  1: initiator accepts the beat.
- `resp_data`  out  `ADDR_W`: line word.
- `resp_idx`  out  `OFFSET_W`: beat index, 0..LINE_WORDS-1.
- `resp_last`  out  1: final beat of the line.
- `busy`  out  1: state is not IDLE.
- `fill_count`  out  32: number of completed fills.

## Operation
- Reset and synchronicity are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- States:
  - IDLE
  - WAIT: latency countdown.
  - BURST
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch base = `req_addr` with bits [OFFSET_W-1:0] cleared, and clear the beat index.
  - Go to WAIT with counter=`LATENCY`. If `LATENCY`==0, go directly to BURST.
- WAIT:
  - Counter decrements once per cycle.
  - Transition to BURST on the cycle the counter would reach 0.
  - WAIT therefore occupies exactly `LATENCY` cycles.
- BURST:
  - `resp_valid`=1, `resp_data`=base+idx, `resp_idx`=idx, `resp_last`=(idx==LINE_WORDS-1).
  - On `resp_valid`&&`resp_ready`:
    - Not last: idx+1 and stay in BURST.
    - Last: go to IDLE and increment `fill_count`.
- Arithmetic:
  - base+idx never carries out of the offset field because base is line-aligned.
  - `fill_count` wraps modulo 2^32.
- Backpressure:
  - While `resp_valid`=1 and `resp_ready`=0, `resp_data`, `resp_idx` and `resp_last` hold stable.
  - `resp_valid` never drops without a handshake.
- `req_addr` changes after acceptance have no effect.
- `req_valid` is ignored outside IDLE; `req_ready`=0 there.
- There is no request queue: the initiator holds `req_valid` until it sees `req_ready`.

## Timing
- Reset values (asynchronous; all take effect immediately on `rst_n` assertion):
  - State IDLE.
  - `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_idx`=0, `resp_last`=0, `busy`=0, `fill_count`=0.
- Reset mid-WAIT or mid-BURST: the burst is abandoned, `fill_count` is not incremented, and no partial beats are delivered after reset release.
- All outputs are registered or decoded from state only. There are no combinational paths from `resp_ready` or `req_valid` to any output.
- Acceptance at edge E0:
  - Beat 0 is valid in the cycle after edge E0+`LATENCY`.
  - With `LATENCY`=0, beat 0 is valid the cycle immediately after E0.
- With `resp_ready` held high, beats issue on consecutive cycles. A full line takes `LATENCY`+`LINE_WORDS` cycles after acceptance.
- After the last handshake, `req_ready`=1 in the next cycle. The minimum request-to-request spacing is `LATENCY`+`LINE_WORDS`+1 cycles.
- `fill_count` is updated in the same edge as the last handshake.

## Structure
- Shared package `dm_cache_pkg` holds the constants common to the cache and this responder:
  - `ADDR_W`=32, `LINE_WORDS`=16, `OFFSET_W`=4, `INDEX_W`=8, `TAG_W`=20.
  - The state enum {IDLE, WAIT, BURST}.
- No sub-module is warranted: the latency counter and beat counter are small enough to live in one module with a single FSM.

## Test plan
- Reset, then one request with `req_addr`=0x0000_1234, `LATENCY`=4, `resp_ready`=1:
  - Beats 0..15 carry 0x0000_1230..0x0000_123F.
  - `resp_last` is asserted only on idx 15.
  - Beat 0 appears 4 cycles after acceptance.
  - `fill_count`=1.
- Same request with `resp_ready` toggling 1,0,0,1,…:
  - Data and idx hold stable during stalls.
  - Exactly 16 handshakes occur with no duplicated or skipped idx.
- `LATENCY`=0 with `req_addr`=0xFFFF_FFF0:
  - Beat 0 valid the cycle after acceptance.
  - Last data = 0xFFFF_FFFF.
- `req_valid` held high continuously with three different addresses:
  - `req_ready` is low while `busy`.
  - Three fills complete, each spaced at least `LATENCY`+17 cycles apart.
  - `fill_count`=3.
- Assert `rst_n` low during beat 7:
  - All outputs reach reset values immediately.
  - `fill_count` stays at its pre-fill value reset to 0.
  - A new request after release returns beat 0 of the new line.
